// File: rtl/step_down_counter_if.sv
// Handshake/data bundle between a step_down_counter and the logic driving it.
// master drives load/dec strobes; slave (the counter) returns count and status.
interface step_down_counter_if #(
   parameter int unsigned WIDTH = 32
);
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             dec;
   logic [WIDTH-1:0] value;
   logic             zero;
   logic             underflow;
   logic             done;
   logic             busy;

   modport master (
      output load, load_value, dec,
      input  value, zero, underflow, done, busy
   );

   modport slave (
      input  load, load_value, dec,
      output value, zero, underflow, done, busy
   );
endinterface

// File: rtl/step_down_counter.sv
// Loadable down-counter subtracting STEP per dec, with done pulse and sticky underflow.
// STEP_DOWN_SAT_EN: when defined, an overshooting dec saturates value to 0 instead of wrapping.
module step_down_counter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned STEP  = 3
) (
   input logic                clock,
   input logic                clear_n,
   step_down_counter_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StCount, StExpired} state_e;

   localparam logic [WIDTH-1:0] StepW = WIDTH'(STEP);

   state_e           state_q;
   logic [WIDTH-1:0] value_q;
   logic             underflow_q;
   logic             done_q;
   logic             busy_q;

   logic [WIDTH:0]   diff;
   logic             borrow;

   // Extra top bit captures the borrow; it never feeds back into value.
   always_comb begin
      diff   = {1'b0, value_q} - {1'b0, StepW};
      borrow = diff[WIDTH];
   end

   always_ff @(negedge clock) begin
      if (!clear_n) begin
         state_q     <= StIdle;
         value_q     <= '0;
         underflow_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.load) begin
            value_q     <= bus.load_value;
            underflow_q <= 1'b0;
            if (bus.load_value != '0) begin
               state_q <= StCount;
               busy_q  <= 1'b1;
            end else begin
               state_q <= StExpired;
               busy_q  <= 1'b0;
               // Repeated zero loads must not stretch done over two periods.
               done_q  <= ~done_q;
            end
         end else if (state_q == StCount && bus.dec) begin
            if (borrow) begin
               underflow_q <= 1'b1;
               state_q     <= StExpired;
               busy_q      <= 1'b0;
               done_q      <= 1'b1;
`ifdef STEP_DOWN_SAT_EN
               value_q     <= '0;
`else
               value_q     <= diff[WIDTH-1:0];
`endif
            end else begin
               value_q <= diff[WIDTH-1:0];
               if (diff[WIDTH-1:0] == '0) begin
                  state_q <= StExpired;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.value     = value_q;
   assign bus.zero      = (value_q == '0);
   assign bus.underflow = underflow_q;
   assign bus.done      = done_q;
   assign bus.busy      = busy_q;
endmodule
